// File: rtl/sha_sched_pkg.sv
// sha_sched_pkg: shared FSM states and SHA-2 sigma helpers for the schedule stream.
package sha_sched_pkg;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND
  } state_e;
  // row 0: SHA-256, row 1: SHA-512; columns s0 ror/ror/shr then s1 ror/ror/shr
  localparam int SIG_AMT [2][6] = '{'{7, 18, 3, 17, 19, 10}, '{1, 8, 7, 19, 61, 6}};
  function automatic int sig_amt(input int w, input int i);
    return SIG_AMT[(w == 64) ? 1 : 0][i];
  endfunction
  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction
  function automatic logic [63:0] sigma(input logic [63:0] x, input int w, input int sel);
    return ror(x, sig_amt(w, sel * 3), w) ^ ror(x, sig_amt(w, sel * 3 + 1), w) ^
           (x >> sig_amt(w, sel * 3 + 2));
  endfunction
endpackage

// File: rtl/msg_sigma.sv
// msg_sigma: combines the four circular-buffer taps into the next schedule word.
module msg_sigma
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] w2,
  input  logic [WORD_W-1:0] w7,
  input  logic [WORD_W-1:0] w15,
  input  logic [WORD_W-1:0] w16,
  output logic [WORD_W-1:0] w
);
  logic [63:0] s0, s1;
  assign s0 = sigma(64'(w15), WORD_W, 0);
  assign s1 = sigma(64'(w2), WORD_W, 1);
  assign w  = WORD_W'(s1 + 64'(w7) + s0 + 64'(w16));
endmodule

// File: rtl/msg_schedule_stream.sv
// msg_schedule_stream: streams the SHA-2 message schedule W_0..W_{ROUNDS-1}
// from one 16-word block using a 16-entry circular buffer.
module msg_schedule_stream
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_t,
  output logic              out_last,
  output logic              busy
);
  state_e            state;
  logic [3:0]        cnt;
  logic [6:0]        t;
  logic [WORD_W-1:0] mem [16];
  logic [WORD_W-1:0] w_calc;
  logic              gen, fire;
  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("msg_schedule_stream: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
    $error("msg_schedule_stream: ROUNDS must be within 16..80");
  end
  assign in_ready = state == LOAD;
  assign busy     = state != IDLE;
  assign fire     = out_valid && out_ready;
  assign gen      = state == EXPAND && t < 7'(ROUNDS) && (!out_valid || out_ready);
  msg_sigma #(.WORD_W(WORD_W)) u_sigma (
    .w2 (mem[t[3:0] - 4'd2]),
    .w7 (mem[t[3:0] - 4'd7]),
    .w15(mem[t[3:0] - 4'd15]),
    .w16(mem[t[3:0]]),
    .w  (w_calc)
  );
  // W_{t-16} lives in slot t&15 and is dead once W_t is produced, so W_t reuses it
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) mem[cnt] <= in_data;
    else if (gen && t >= 7'd16) mem[t[3:0]] <= w_calc;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_t     <= '0;
      out_last  <= 1'b0;
    end else if (start) begin
      state     <= LOAD;
      cnt       <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == LOAD) begin
      if (in_valid) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) state <= EXPAND;
      end
    end else if (state == EXPAND) begin
      if (gen) begin
        out_valid <= 1'b1;
        out_data  <= t < 7'd16 ? mem[t[3:0]] : w_calc;
        out_t     <= t;
        out_last  <= t == 7'(ROUNDS - 1);
        t         <= t + 7'd1;
      end else if (fire) out_valid <= 1'b0;
      if (fire && out_last) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_msg_schedule_stream.sv
// tb_msg_schedule_stream: scoreboard bench for the SHA-256 and SHA-512 schedule streams.
module tb_msg_schedule_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n, start, in_valid, out_ready, in_ready, out_valid, out_last, busy;
  logic [31:0] in_data, out_data;
  logic [6:0]  out_t;
  logic        start_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [63:0] in_data_b, out_data_b;
  logic [6:0]  out_t_b;
  msg_schedule_stream dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_t(out_t), .out_last(out_last), .busy(busy)
  );
  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_t(out_t_b), .out_last(out_last_b), .busy(busy_b)
  );
  typedef struct {
    logic [63:0] d;
    logic [6:0]  t;
    logic        last;
  } exp_t;
  exp_t        q[$], qb[$];
  exp_t        e_a, e_b;
  int          errors = 0, checks = 0;
  logic [31:0] blk[16];
  logic [63:0] blkb[16];
  logic [31:0] obs[64];
  logic [63:0] obsb[80];
  int          nwords, nlast, nwb;
  logic        stalled = 1'b0;
  logic [31:0] prev_d;
  logic [6:0]  prev_t;
  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  task automatic push32();
    logic [31:0] w[64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (r32(w[i-2], 17) ^ r32(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
                  (r32(w[i-15], 7) ^ r32(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      q.push_back('{64'(w[i]), 7'(i), i == 63});
    end
  endtask
  task automatic push64();
    logic [63:0] w[80];
    for (int i = 0; i < 80; i++) begin
      if (i < 16) w[i] = blkb[i];
      else w[i] = (r64(w[i-2], 19) ^ r64(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7] +
                  (r64(w[i-15], 1) ^ r64(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
      qb.push_back('{w[i], 7'(i), i == 79});
    end
  endtask
  always @(negedge clk) begin
    if (!reset_n) stalled = 1'b0;
    else begin
      if (stalled && out_valid) begin
        checks++;
        if (out_data !== prev_d || out_t !== prev_t) begin
          errors++;
          $display("FAIL stall_hold: got %h t=%0d, held value %h t=%0d", out_data, out_t, prev_d, prev_t);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h t=%0d, expected no word", out_data, out_t);
        end else begin
          e_a = q.pop_front();
          if (out_data !== e_a.d[31:0] || out_t !== e_a.t || out_last !== e_a.last) begin
            errors++;
            $display("FAIL word256: got %h t=%0d last=%b, expected %h t=%0d last=%b",
                     out_data, out_t, out_last, e_a.d[31:0], e_a.t, e_a.last);
          end
        end
        obs[out_t] = out_data;
        nwords++;
        if (out_last) nlast++;
      end
      stalled = out_valid && !out_ready;
      prev_d  = out_data;
      prev_t  = out_t;
    end
  end
  always @(negedge clk) begin
    if (reset_n && out_valid_b && out_ready_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL extra_word512: got %h t=%0d, expected no word", out_data_b, out_t_b);
      end else begin
        e_b = qb.pop_front();
        if (out_data_b !== e_b.d || out_t_b !== e_b.t || out_last_b !== e_b.last) begin
          errors++;
          $display("FAIL word512: got %h t=%0d last=%b, expected %h t=%0d last=%b",
                   out_data_b, out_t_b, out_last_b, e_b.d, e_b.t, e_b.last);
        end
      end
      obsb[out_t_b] = out_data_b;
      nwb++;
    end
  end
  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic feed(input int n);
    if (n == 16) push32();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic run_out(input bit rnd, input int budget);
    for (int c = 0; c < budget && (q.size() != 0 || busy); c++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
    checks++;
    if (q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending busy=%b, expected 0 pending busy=0", q.size(), busy);
    end
  endtask
  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    if (out_t !== 7'h0) begin errors++; $display("FAIL reset_out_t: got %0d, expected 0", out_t); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_abc();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    nwords = 0;
    nlast  = 0;
    do_start();
    checks += 2;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_load: got busy=%b in_ready=%b, expected 1 1", busy, in_ready);
    end
    feed(16);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL first_latency_early: got out_valid=%b, expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_t !== 7'd0) begin
      errors++;
      $display("FAIL first_latency: got valid=%b t=%0d, expected valid=1 t=0", out_valid, out_t);
    end
    run_out(1'b0, 200);
    checks += 4;
    if (nwords != 64) begin errors++; $display("FAIL abc_count: got %0d, expected 64", nwords); end
    if (nlast != 1) begin errors++; $display("FAIL abc_last_count: got %0d, expected 1", nlast); end
    if (obs[16] !== 32'h61626380) begin errors++; $display("FAIL abc_w16: got %h, expected 61626380", obs[16]); end
    if (obs[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_w17: got %h, expected 000f0000", obs[17]); end
  endtask
  task automatic test_random_stall();
    rand_blk();
    nwords = 0;
    do_start();
    feed(16);
    run_out(1'b1, 1000);
    checks++;
    if (nwords != 64) begin errors++; $display("FAIL stall_count: got %0d, expected 64", nwords); end
  endtask
  task automatic test_abort();
    int c;
    rand_blk();
    do_start();
    feed(16);
    out_ready = 1'b1;
    for (c = 0; c < 100 && !(out_valid && out_t == 7'd20); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(out_valid && out_t == 7'd20)) begin
      errors++;
      $display("FAIL abort_reach_t20: got t=%0d valid=%b, expected t=20 valid=1", out_t, out_valid);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b, expected 1", in_ready); end
    q.delete();
    rand_blk();
    nwords = 0;
    feed(16);
    run_out(1'b0, 200);
    checks++;
    if (nwords != 64) begin errors++; $display("FAIL abort_count: got %0d, expected 64", nwords); end
  endtask
  task automatic test_reset_mid_load();
    rand_blk();
    do_start();
    feed(7);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b, expected 0", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL midreset_out_data: got %h, expected 0", out_data); end
    if (out_valid !== 1'b0 || out_t !== 7'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: got valid=%b t=%0d last=%b, expected 0 0 0", out_valid, out_t, out_last);
    end
    #4;
    reset_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rand_blk();
    nwords = 0;
    do_start();
    feed(16);
    run_out(1'b0, 200);
    checks++;
    if (nwords != 64) begin errors++; $display("FAIL midreset_count: got %0d, expected 64", nwords); end
  endtask
  task automatic test_back_to_back();
    int c;
    rand_blk();
    do_start();
    feed(16);
    out_ready = 1'b1;
    for (c = 0; c < 200 && !(out_valid && out_last); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(out_valid && out_last)) begin
      errors++;
      $display("FAIL b2b_reach_last: got valid=%b last=%b, expected 1 1", out_valid, out_last);
    end
    do_start();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    rand_blk();
    nwords = 0;
    feed(16);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_t !== 7'd0) begin
      errors++;
      $display("FAIL b2b_gap: got valid=%b t=%0d, expected valid=1 t=0", out_valid, out_t);
    end
    run_out(1'b0, 200);
    checks++;
    if (nwords != 64) begin errors++; $display("FAIL b2b_count: got %0d, expected 64", nwords); end
  endtask
  task automatic test_sha512();
    int c;
    for (int i = 0; i < 16; i++) blkb[i] = 64'h0;
    blkb[0]  = 64'h6162638000000000;
    blkb[15] = 64'h18;
    nwb = 0;
    out_ready_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    push64();
    for (int i = 0; i < 16; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = blkb[i];
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    for (c = 0; c < 300 && (qb.size() != 0 || busy_b); c++) begin
      @(posedge clk); #1;
    end
    checks += 4;
    if (qb.size() != 0 || busy_b) begin errors++; $display("FAIL sha512_timeout: got %0d pending, expected 0", qb.size()); end
    if (nwb != 80) begin errors++; $display("FAIL sha512_count: got %0d, expected 80", nwb); end
    if (obsb[16] !== 64'h6162638000000000) begin errors++; $display("FAIL sha512_w16: got %h, expected 6162638000000000", obsb[16]); end
    if (obsb[17] !== 64'h00030000000000C0) begin errors++; $display("FAIL sha512_w17: got %h, expected 00030000000000c0", obsb[17]); end
  endtask
  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    test_reset();
    test_abc();
    test_random_stall();
    test_abort();
    test_reset_mid_load();
    test_back_to_back();
    test_sha512();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
